// File: rtl/sc_pkg.sv
// Shared stochastic-computing definitions: decoder FSM encoding and a
// reference helper for the signed bipolar estimate.
package sc_pkg;

    typedef enum logic [1:0] {
        SC_IDLE  = 2'd0,
        SC_ACCUM = 2'd1,
        SC_HOLD  = 2'd2
    } sc_dec_state_t;

    // Bipolar estimate of a window of 2**win_log2 bits holding `ones` ones.
    function automatic int sc_bipolar(input int ones, input int win_log2);
        return 2 * ones - (1 << win_log2);
    endfunction

endpackage

// File: rtl/sc_stream_decoder_if.sv
// Bit-in / result-out stream bundle of the stochastic decoder.
// Both channels use valid/ready: a transfer happens on every rising clock edge
// where valid && ready; the sender holds its payload stable until then.
interface sc_stream_decoder_if #(
    parameter int WIN_LOG2 = 6
);
    localparam int CNT_W = WIN_LOG2 + 1;

    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic [CNT_W:0]   out_value;

    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_count, out_value
    );

    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_count, out_value
    );
endinterface

// File: rtl/sc_ones_counter.sv
// Window bit counter and ones accumulator with end-of-window detect.
// clear dominates enable, so an abort on the last bit leaves both counters at zero.
module sc_ones_counter #(
    parameter int WIN_LOG2 = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                enable,
    input  logic                bit_in,
    output logic [WIN_LOG2-1:0] bit_cnt,
    output logic [WIN_LOG2:0]   ones,
    output logic                last
);
    localparam logic [WIN_LOG2-1:0] LAST_IDX = '1;

    assign last = enable && (bit_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bit_cnt <= '0;
            ones    <= '0;
        end else if (enable) begin
            ones <= ones + {{WIN_LOG2{1'b0}}, bit_in};
            // bit_cnt parks at N-1; only a clear brings it back to zero
            if (!last) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over a 2**WIN_LOG2 bit window
// and offers the count (and optional bipolar estimate) on a valid/ready port.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int WIN_LOG2     = 6,
    parameter int BIPOLAR      = 0,
    parameter int AUTO_RESTART = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output sc_dec_state_t       dbg_state,
    output logic [WIN_LOG2-1:0] dbg_bit_cnt,
    sc_stream_decoder_if.slave  io
);
    localparam int             CNT_W = WIN_LOG2 + 1;
    localparam logic [CNT_W:0] N_EXT = (CNT_W + 1)'(1 << WIN_LOG2);

    sc_dec_state_t       state;
    logic                take;
    logic                clear;
    logic                win_last;
    logic [WIN_LOG2-1:0] bit_cnt;
    logic [CNT_W-1:0]    ones;
    logic [CNT_W-1:0]    total;
    logic [CNT_W:0]      bipolar_value;

    assign io.in_ready  = (state == SC_ACCUM);
    assign busy         = (state != SC_IDLE);
    assign dbg_state    = state;
    assign dbg_bit_cnt  = bit_cnt;
    assign take         = io.in_valid && io.in_ready;

    // The final bit is folded in here so the result appears one cycle after it.
    assign total         = ones + {{WIN_LOG2{1'b0}}, io.in_bit};
    assign bipolar_value = ({1'b0, total} << 1) - N_EXT;

    always_comb begin
        clear = 1'b0;
        if (state == SC_IDLE && start) begin
            clear = 1'b1;
        end else if (state != SC_IDLE && abort) begin
            clear = 1'b1;
        end else if (state == SC_HOLD && io.out_ready && AUTO_RESTART != 0) begin
            clear = 1'b1;
        end
    end

    sc_ones_counter #(.WIN_LOG2(WIN_LOG2)) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .enable  (take),
        .bit_in  (io.in_bit),
        .bit_cnt (bit_cnt),
        .ones    (ones),
        .last    (win_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SC_IDLE;
            io.out_valid <= 1'b0;
            io.out_count <= '0;
            io.out_value <= '0;
        end else begin
            case (state)
                SC_IDLE: begin
                    if (start) begin
                        state <= SC_ACCUM;
                    end
                end
                SC_ACCUM: begin
                    // abort outranks a window that would close on this same cycle
                    if (abort) begin
                        state        <= SC_IDLE;
                        io.out_count <= '0;
                        io.out_value <= '0;
                    end else if (win_last) begin
                        state        <= SC_HOLD;
                        io.out_valid <= 1'b1;
                        io.out_count <= total;
                        io.out_value <= (BIPOLAR != 0) ? bipolar_value : '0;
                    end
                end
                SC_HOLD: begin
                    if (abort) begin
                        state        <= SC_IDLE;
                        io.out_valid <= 1'b0;
                        io.out_count <= '0;
                        io.out_value <= '0;
                    end else if (io.out_ready) begin
                        io.out_valid <= 1'b0;
                        state        <= (AUTO_RESTART != 0) ? SC_ACCUM : SC_IDLE;
                    end
                end
                default: begin
                    state        <= SC_IDLE;
                    io.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sc_stream_decoder.sv
// Bench for sc_stream_decoder: a one-shot bipolar instance driven from a vector
// table and corner sequences, plus an auto-restart instance for back-to-back windows.
module tb_sc_stream_decoder;
    import sc_pkg::*;

    localparam int WIN_LOG2 = 6;

    typedef struct {
        logic [63:0] bits;
        bit          gaps;
        int          hold;
        logic [6:0]  exp_count;
        logic [7:0]  exp_value;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_a, abort_a, busy_a;
    logic          start_b, abort_b, busy_b;
    sc_dec_state_t st_a, st_b;
    logic [5:0]    bc_a, bc_b;

    int            n_vec = 0;
    int            n_err = 0;
    logic [14:0]   exp_a_q[$];
    logic [14:0]   exp_b_q[$];
    logic [14:0]   mon_a_exp, mon_b_exp;
    vec_t          tbl[8];

    sc_stream_decoder_if #(.WIN_LOG2(WIN_LOG2)) a_if ();
    sc_stream_decoder_if #(.WIN_LOG2(WIN_LOG2)) b_if ();

    sc_stream_decoder #(.WIN_LOG2(WIN_LOG2), .BIPOLAR(1), .AUTO_RESTART(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .busy(busy_a),
        .dbg_state(st_a), .dbg_bit_cnt(bc_a), .io(a_if.slave)
    );

    sc_stream_decoder #(.WIN_LOG2(WIN_LOG2), .BIPOLAR(0), .AUTO_RESTART(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .busy(busy_b),
        .dbg_state(st_b), .dbg_bit_cnt(bc_b), .io(b_if.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit sel, input logic v, input logic b);
        if (sel) begin
            b_if.in_valid = v;
            b_if.in_bit   = b;
        end else begin
            a_if.in_valid = v;
            a_if.in_bit   = b;
        end
    endtask

    // Sends bits[lo..hi-1]; each bit is held until it transfers with in_ready high.
    task automatic send_bits(input bit sel, input logic [63:0] bits, input int lo,
                             input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) begin
            int  g;
            int  w;
            bit  rdy;
            if (gaps) begin
                g = $urandom_range(0, 3);
                for (int k = 0; k < g; k++) begin
                    set_in(sel, 1'b0, 1'($urandom));
                    tick();
                end
            end
            set_in(sel, 1'b1, bits[i]);
            w = 0;
            do begin
                rdy = sel ? b_if.in_ready : a_if.in_ready;
                tick();
                w++;
            end while (!rdy && w < 100);
            if (!rdy) begin
                n_vec++;
                n_err++;
                $display("FAIL ready_timeout: in_ready low for %0d cycles, required 1", w);
            end
        end
        set_in(sel, 1'b0, 1'b0);
    endtask

    // One full window on dut_a, including optional out_ready back-pressure.
    task automatic run_window(input vec_t v);
        exp_a_q.push_back({v.exp_count, v.exp_value});
        a_if.out_ready = (v.hold == 0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        send_bits(1'b0, v.bits, 0, 64, v.gaps);
        @(negedge clk);
        check("latency_out_valid", a_if.out_valid, 1);
        check("hold_in_ready", a_if.in_ready, 0);
        for (int c = 0; c < v.hold; c++) begin
            tick();
            start_a = (c == 2);
            a_if.in_valid = 1'b1;
            a_if.in_bit   = 1'b1;
            @(negedge clk);
            check("hold_out_valid", a_if.out_valid, 1);
            check("hold_out_count", a_if.out_count, v.exp_count);
            check("hold_in_ready_stall", a_if.in_ready, 0);
        end
        if (v.hold != 0) begin
            tick();
            start_a = 1'b0;
            set_in(1'b0, 1'b0, 1'b0);
            a_if.out_ready = 1'b1;
        end
        tick();
        @(negedge clk);
        check("done_out_valid", a_if.out_valid, 0);
        check("done_busy", busy_a, 0);
        tick();
    endtask

    // ---------------- scoreboards ----------------
    always @(negedge clk) begin
        if (!rst && a_if.out_valid && a_if.out_ready) begin
            if (exp_a_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL a_unexpected_result: got count %0d, required no result", a_if.out_count);
            end else begin
                mon_a_exp = exp_a_q.pop_front();
                check("a_result", {a_if.out_count, a_if.out_value}, mon_a_exp);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_if.out_valid && b_if.out_ready) begin
            if (exp_b_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL b_unexpected_result: got count %0d, required no result", b_if.out_count);
            end else begin
                mon_b_exp = exp_b_q.pop_front();
                check("b_result", {b_if.out_count, b_if.out_value}, mon_b_exp);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [63:0] rnd;
        int          rnd_ones;

        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0,  7'd64, 8'h40};
        tbl[1] = '{64'h5555_5555_5555_5555, 1'b0, 0,  7'd32, 8'h00};
        tbl[2] = '{64'h0000_0000_0000_0000, 1'b0, 0,  7'd0,  8'hC0};
        tbl[3] = '{64'h000F_000F_000F_000F, 1'b1, 0,  7'd16, 8'hE0};
        tbl[4] = '{64'hFFFF_FFFF_FFFF_0000, 1'b0, 10, 7'd48, 8'h20};
        tbl[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 0,  7'd63, 8'h3E};
        tbl[6] = '{64'h8000_0000_0000_0000, 1'b0, 0,  7'd1,  8'hC2};
        rnd      = {$urandom, $urandom};
        rnd_ones = $countones(rnd);
        tbl[7] = '{rnd, 1'b1, 3, 7'(rnd_ones), 8'(sc_bipolar(rnd_ones, WIN_LOG2))};

        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        a_if.in_valid = 1'b0; a_if.in_bit = 1'b0; a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.in_bit = 1'b0; b_if.out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_out_valid", a_if.out_valid, 0);
        check("rst_out_count", a_if.out_count, 0);
        check("rst_out_value", a_if.out_value, 0);
        check("rst_busy", busy_a, 0);
        check("rst_in_ready", a_if.in_ready, 0);
        check("rst_state", st_a, SC_IDLE);
        check("rst_bit_cnt", bc_a, 0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_window(tbl[i]);
        end

        // abort after 30 bits
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        send_bits(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 30, 1'b0);
        @(negedge clk);
        check("bit_cnt_30", bc_a, 30);
        @(posedge clk);
        #1;
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        @(negedge clk);
        check("abort_busy", busy_a, 0);
        check("abort_out_valid", a_if.out_valid, 0);
        check("abort_bit_cnt", bc_a, 0);
        tick();

        // start and abort together in IDLE: start wins; then reset after 40 bits
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        @(negedge clk);
        check("start_beats_abort", busy_a, 1);
        @(posedge clk);
        #1;
        send_bits(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 40, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy_a, 0);
        check("midrst_bit_cnt", bc_a, 0);
        check("midrst_out_valid", a_if.out_valid, 0);
        tick();

        // abort on the very cycle the last bit arrives
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        send_bits(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 63, 1'b0);
        set_in(1'b0, 1'b1, 1'b1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        set_in(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("abort_last_out_valid", a_if.out_valid, 0);
        check("abort_last_busy", busy_a, 0);
        tick();

        run_window(tbl[3]);

        // auto-restart instance: two back-to-back windows, stray starts mid-window
        exp_b_q.push_back({7'd48, 8'h00});
        exp_b_q.push_back({7'd8, 8'h00});
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        send_bits(1'b1, 64'h0000_FFFF_FFFF_FFFF, 0, 20, 1'b0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        send_bits(1'b1, 64'h0000_FFFF_FFFF_FFFF, 20, 64, 1'b1);
        send_bits(1'b1, 64'h0000_0000_0000_00FF, 0, 64, 1'b0);
        @(negedge clk);
        check("b_latency_out_valid", b_if.out_valid, 1);
        tick();
        @(negedge clk);
        check("b_restart_busy", busy_b, 1);
        check("b_restart_state", st_b, SC_ACCUM);
        check("b_restart_in_ready", b_if.in_ready, 1);
        check("b_restart_bit_cnt", bc_b, 0);
        @(posedge clk);
        #1;
        abort_b = 1'b1;
        tick();
        abort_b = 1'b0;
        @(negedge clk);
        check("b_abort_busy", busy_b, 0);
        tick();
        tick();

        check("a_queue_drained", exp_a_q.size(), 0);
        check("b_queue_drained", exp_b_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
